// File: rtl/btn_event_decoder.sv
// Turns a debounced button level into one-cycle click / double-click / long-press events.
// Optional auto-repeat while long-held is built only when BTN_AUTO_REPEAT_EN is defined.
module btn_event_decoder #(
  parameter int LONG_CYCLES   = 12500000,
  parameter int DBL_CYCLES    = 5000000,
  parameter int REPEAT_CYCLES = 2500000,
  parameter int CNT_W         = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnDown,
  output logic       shortClick,
  output logic       doubleClick,
  output logic       longPress,
  output logic       btnRepeat,
  output logic       btnHeld,
  output logic [7:0] eventCount
);

  // Elaboration-time legality of the timing parameters.
  if (CNT_W < 2 || CNT_W > 32) begin : g_bad_width
    $error("btn_event_decoder: CNT_W out of range");
  end
  if (LONG_CYCLES < 2 || longint'(LONG_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_long
    $error("btn_event_decoder: LONG_CYCLES out of range");
  end
  if (DBL_CYCLES < 2 || longint'(DBL_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_dbl
    $error("btn_event_decoder: DBL_CYCLES out of range");
  end
  if (REPEAT_CYCLES < 2 || longint'(REPEAT_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_rep
    $error("btn_event_decoder: REPEAT_CYCLES out of range");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  // timer holds the number of samples already counted in the current state,
  // so "timer == X_LAST" means the sample at this edge is the X_CYCLES-th one.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state, stateNext;
  logic [CNT_W-1:0] timer, timerNext;
  logic             shortNext, doubleNext, longNext;
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic             repeatNext;
`endif

  always_comb begin
    stateNext  = state;
    timerNext  = timer;
    shortNext  = 1'b0;
    doubleNext = 1'b0;
    longNext   = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
    repeatNext = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (btnDown) begin
          stateNext = PRESS1;
          timerNext = ONE;
        end
      end
      PRESS1: begin
        if (!btnDown) begin
          stateNext = WAIT2;
          timerNext = ONE;
        end else if (timer == LONG_LAST) begin
          longNext  = 1'b1;
          stateNext = LONG;
          timerNext = '0;
        end else begin
          timerNext = timer + ONE;
        end
      end
      WAIT2: begin
        if (btnDown) begin
          stateNext = PRESS2;
          timerNext = '0;
        end else if (timer == DBL_LAST) begin
          shortNext = 1'b1;
          stateNext = IDLE;
          timerNext = '0;
        end else begin
          timerNext = timer + ONE;
        end
      end
      PRESS2: begin
        if (!btnDown) begin
          doubleNext = 1'b1;
          stateNext  = IDLE;
          timerNext  = '0;
        end
      end
      LONG: begin
        if (!btnDown) begin
          stateNext = IDLE;
          timerNext = '0;
        end
`ifdef BTN_AUTO_REPEAT_EN
        // In LONG the timer counts high samples since the last long/repeat pulse.
        else if (timer == REP_LAST) begin
          repeatNext = 1'b1;
          timerNext  = '0;
        end else begin
          timerNext = timer + ONE;
        end
`endif
      end
      default: begin
        stateNext = IDLE;
        timerNext = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      shortClick  <= 1'b0;
      doubleClick <= 1'b0;
      longPress   <= 1'b0;
      btnHeld     <= 1'b0;
      eventCount  <= 8'd0;
    end else begin
      state       <= stateNext;
      timer       <= timerNext;
      shortClick  <= shortNext;
      doubleClick <= doubleNext;
      longPress   <= longNext;
      btnHeld     <= (stateNext == PRESS1) || (stateNext == PRESS2) || (stateNext == LONG);
      if (shortNext || doubleNext || longNext) begin
        eventCount <= eventCount + 8'd1;
      end
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btnRepeat <= 1'b0;
    end else begin
      btnRepeat <= repeatNext;
    end
  end
`else
  assign btnRepeat = 1'b0;
`endif

endmodule
